// File: rtl/alu_result_queue_if.sv
// Handshake/status bundle between the ALU result queue and its consumer.
// slave = queue side, master = producer/consumer side.
interface alu_result_queue_if #(
  parameter int W     = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_y;
  logic          in_c;
  logic          in_v;
  logic          in_n;
  logic          in_z;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_y;
  logic          out_c;
  logic          out_v;
  logic          out_n;
  logic          out_z;
  logic [CW-1:0] count;
  logic [3:0]    last_nzcv;
  logic [3:0]    sticky_nzcv;
  logic          flags_clr;
  logic [7:0]    drop_cnt;

  modport slave (
    input  in_valid, in_y, in_c, in_v, in_n, in_z, out_ready, flags_clr,
    output in_ready, out_valid, out_y, out_c, out_v, out_n, out_z,
           count, last_nzcv, sticky_nzcv, drop_cnt
  );

  modport master (
    output in_valid, in_y, in_c, in_v, in_n, in_z, out_ready, flags_clr,
    input  in_ready, out_valid, out_y, out_c, out_v, out_n, out_z,
           count, last_nzcv, sticky_nzcv, drop_cnt
  );
endinterface

// File: rtl/alu_result_queue.sv
// FIFO of ALU results {y,c,v,n,z} with last/sticky flag status and a
// saturating count of stalled producer cycles.
module alu_rq_entry #(
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [EW-1:0] d_i,
  output logic [EW-1:0] q_o
);
  // Storage is deliberately not reset; contents only matter once written.
  logic [EW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (we_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module alu_result_queue #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  alu_result_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = W + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         v;
    logic         n;
    logic         z;
  } entry_t;

  entry_t                wr_ent;
  entry_t [DEPTH-1:0]    ent;
  entry_t                head;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    last_q, last_d;
  logic [3:0]    sticky_q, sticky_d;
  logic [7:0]    drop_q, drop_d;

  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic          drop;
  logic [3:0]    push_nzcv;

  // No pass-through when full: readiness depends only on stored occupancy.
  assign in_ready  = !rst && (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready && !rst;
  assign drop      = bus.in_valid && !in_ready && !rst;
  assign push_nzcv = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};

  assign wr_ent = '{y: bus.in_y, c: bus.in_c, v: bus.in_v,
                    n: bus.in_n, z: bus.in_z};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [EW-1:0] q;
    alu_rq_entry #(.EW(EW)) u_ent (
      .clk  (clk),
      .we_i (push && (wr_ptr_q == AW'(i))),
      .d_i  (wr_ent),
      .q_o  (q)
    );
    assign ent[i] = entry_t'(q);
  end

  assign head = ent[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    sticky_d = sticky_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push) last_d = push_nzcv;

    // Clear wins over accumulation, but a same-cycle push still lands.
    if (bus.flags_clr) sticky_d = push ? push_nzcv : 4'b0000;
    else if (push)     sticky_d = sticky_q | push_nzcv;

    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      sticky_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_y       = head.y;
  assign bus.out_c       = head.c;
  assign bus.out_v       = head.v;
  assign bus.out_n       = head.n;
  assign bus.out_z       = head.z;
  assign bus.count       = count_q;
  assign bus.last_nzcv   = last_q;
  assign bus.sticky_nzcv = sticky_q;
  assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: expected entries go into a scoreboard
// queue at stimulus time; a negedge monitor checks every popped head.
module tb_alu_result_queue;
  localparam int W = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_result_queue_if #(.W(W), .DEPTH(DEPTH)) bus ();

  alu_result_queue #(.W(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];   // {y, n, z, c, v}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] y, input logic [3:0] nzcv, input bit expect_accept);
    bus.in_valid = 1'b1;
    bus.in_y = y;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = nzcv;
    if (expect_accept) sb.push_back({y, nzcv});
  endtask

  // Monitor: a pop happens on the next posedge whenever this holds at negedge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got y=%0h expected no output", bus.out_y);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("pop_entry", {bus.out_y, bus.out_n, bus.out_z, bus.out_c, bus.out_v}, e);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b1;
    bus.in_y = 4'hF;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = 4'b1111;
    bus.out_ready = 1'b0;
    bus.flags_clr = 1'b0;

    // Reset, two cycles, with in_valid held
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_count", bus.count, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_drop", bus.drop_cnt, 0);
      check("rst_last", bus.last_nzcv, 0);
      check("rst_sticky", bus.sticky_nzcv, 0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Single entry
    drive(4'hA, 4'b1010, 1);
    tick();
    bus.in_valid = 1'b0;
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_y", bus.out_y, 4'hA);
    check("single_last", bus.last_nzcv, 4'b1010);
    check("single_count", bus.count, 1);
    tick();
    check("single_hold_y", bus.out_y, 4'hA);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_pop_count", bus.count, 0);
    check("single_pop_valid", bus.out_valid, 0);

    // Fill and drop
    for (int k = 1; k <= 6; k++) begin
      drive(4'(k), 4'b0000, k <= 4);
      tick();
    end
    bus.in_valid = 1'b0;
    check("fill_count", bus.count, 4);
    check("fill_in_ready", bus.in_ready, 0);
    check("fill_drop", bus.drop_cnt, 2);
    bus.out_ready = 1'b1;
    tick();
    check("full_pop_count", bus.count, 3);
    check("full_pop_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 3; k++) tick();
    bus.out_ready = 1'b0;
    check("drain_count", bus.count, 0);

    // Streaming push/pop across pointer wrap
    bus.out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive(4'(k), 4'b0000, 1);
      tick();
      check("stream_count", bus.count, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_end_count", bus.count, 0);

    // Sticky flags
    bus.flags_clr = 1'b1;
    tick();
    bus.flags_clr = 1'b0;
    check("sticky_clr0", bus.sticky_nzcv, 4'b0000);
    drive(4'h3, 4'b1000, 1);
    tick();
    drive(4'h4, 4'b0001, 1);
    tick();
    bus.in_valid = 1'b0;
    check("sticky_or", bus.sticky_nzcv, 4'b1001);
    check("sticky_last", bus.last_nzcv, 4'b0001);
    bus.flags_clr = 1'b1;
    drive(4'h0, 4'b0100, 1);
    tick();
    bus.in_valid = 1'b0;
    check("sticky_clr_push", bus.sticky_nzcv, 4'b0100);
    check("sticky_clr_push_last", bus.last_nzcv, 4'b0100);
    tick();
    bus.flags_clr = 1'b0;
    check("sticky_clr_alone", bus.sticky_nzcv, 4'b0000);
    check("sticky_last_held", bus.last_nzcv, 4'b0100);
    tick();
    bus.out_ready = 1'b0;
    check("sticky_drain_count", bus.count, 0);

    // Drop saturation: drop_cnt starts at 2
    for (int k = 0; k < 304; k++) begin
      drive(4'(k), 4'b0000, k < 4);
      tick();
      if (k == 103) check("drop_mid", bus.drop_cnt, 102);
    end
    check("drop_sat", bus.drop_cnt, 255);
    check("drop_sat_count", bus.count, 4);

    // Reset mid-operation discards entries and counts no drops
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    tick();
    check("midrst_count", bus.count, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_drop", bus.drop_cnt, 0);
    sb.delete();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_in_ready_after", bus.in_ready, 1);

    // Post-reset FIFO still works from pointer 0
    drive(4'h7, 4'b0110, 1);
    tick();
    drive(4'h8, 4'b1001, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    check("final_count", bus.count, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the ALU: captures each ALU result word `y` with its flags (`c_out`, `v`, `n`, `z`) into a small FIFO and hands them to the consumer over a valid/ready handshake. It also keeps a last-flags status register and a sticky flags accumulator for condition checks. A saturating counter records stalled producer attempts. Decouples the combinational ALU from a consumer that can stall.

## Interface
- `W`, 4, datapath width; must match the ALU's `W`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.

Clock is `clk`. Reset is `rst`: synchronous and active-high. There is one clock domain.
- `clk` input 1 — clock, rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — ALU result present this cycle.
- `in_ready` output 1 — queue can accept this cycle.
- `in_y` input W — ALU `y`.
- `in_c` input 1 — ALU `c_out`.
- `in_v` input 1 — ALU `v`.
- `in_n` input 1 — ALU `n`.
- `in_z` input 1 — ALU `z`.
- `out_valid` output 1 — head entry valid.
- `out_ready` input 1 — consumer takes head this cycle.
- `out_y` output W — head result.
- `out_c` output 1 — head carry flag.
- `out_v` output 1 — head overflow flag.
- `out_n` output 1 — head negative flag.
- `out_z` output 1 — head zero flag.
- `count` output $clog2(DEPTH)+1 — current occupancy, 0..DEPTH.
- `last_nzcv` output 4 — {n,z,c,v} of the most recently accepted entry.
- `sticky_nzcv` output 4 — bitwise OR of {n,z,c,v} over all entries accepted since reset or last clear.
- `flags_clr` input 1 — clears `sticky_nzcv`.
- `drop_cnt` output 8 — count of cycles with `in_valid && !in_ready`; saturates at 255.

## Operation
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- Storage: DEPTH entries of {y,c,v,n,z}. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
- `in_ready = !rst && (count < DEPTH)`. There is no pass-through when full: a pop in the same cycle does not raise `in_ready`.
- `out_valid = (count != 0)`. `out_*` are driven from the entry at the read pointer. They hold stable while `out_valid && !out_ready`.
- Count update per cycle:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Empty with push: the entry appears on `out_*` the next cycle. A push cannot be popped in its own cycle.
- `last_nzcv` is loaded with the pushed flags on every push. It is otherwise held.
- `sticky_nzcv` next value:
  - `flags_clr` and push: pushed flags.
  - `flags_clr` without push: 0.
  - push without clear: OR with pushed flags.
  - else: held.
- `drop_cnt` increments when `in_valid && !in_ready` and `!rst`. It holds at 255.
- Entry contents are never altered after write. Storage need not be reset.

## Timing
- All state updates on the rising edge of `clk`. Outputs are functions of registered state only; there are no input-to-output combinational paths except `in_ready` depending on `rst`.
- Latency from push to `out_valid` is 1 cycle when empty. Sustained throughput is 1 entry/cycle when neither full nor empty.
- Reset values, asserted during and after the `rst` cycle:
  - `count` = 0, both pointers = 0.
  - `out_valid` = 0, `in_ready` = 0 while `rst` is high and 1 on the first cycle after.
  - `last_nzcv` = 0, `sticky_nzcv` = 0, `drop_cnt` = 0.
  - `out_*` data don't-care while `out_valid` = 0.
- Reset mid-operation discards all entries. Pushes and pops presented in the reset cycle are ignored and are not counted as drops.
- Full (count=DEPTH) with pop: count becomes DEPTH−1. `in_ready` rises the next cycle.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. FIFO order must be preserved across the wrap.

## Test plan
- **Reset:** assert `rst` 2 cycles with `in_valid`=1. Required: `count`=0, `out_valid`=0, `in_ready`=0 during reset, `drop_cnt`=0. After reset: `in_ready`=1.
- **Single entry:** push y=4'hA, n=1, z=0, c=1, v=0 into an empty queue with `out_ready`=0. Next cycle: `out_valid`=1, `out_y`=A, `last_nzcv`=4'b1010, `count`=1. Pop it: `count`=0.
- **Fill and drop:** with `out_ready`=0, push 4'h1..4'h6 on consecutive cycles with `in_valid` held. Required: first four accepted, `count`=4, `in_ready`=0, `drop_cnt`=2. Then pop all: order is 1,2,3,4.
- **Simultaneous push/pop with wrap:** stream 12 values 0..B with `out_ready`=1 and `in_valid`=1. Required: outputs are 0..B in order, `count` ≤ 1 throughout, and the pointers wrap 3 times.
- **Sticky flags:** push flags nzcv=1000, then 0001. Required: `sticky_nzcv`=1001. Assert `flags_clr` with a push of 0100: `sticky_nzcv`=0100. Assert `flags_clr` alone: `sticky_nzcv`=0000.
- **Drop saturation:** hold full with `in_valid`=1 for 300 cycles. Required: `drop_cnt`=255.
